// File: rtl/mux4_rr_arbiter_8bit.sv
// Round-robin arbiter and sequencer for a 4:1 mux. It drives the select lines and a one-hot
// grant, and it registers the chosen word into a valid/ready stage. Each grant is limited to a
// burst of MAX_BURST transfers.
module mux4_rr_arbiter_8bit #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i0,
  input  logic             out_ready,
  output logic [3:0]       gnt,
  output logic             sel1,
  output logic             sel0,
  output logic [WIDTH-1:0] f,
  output logic             out_valid,
  output logic             busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  // Handshake: a word moves downstream on a rising edge where out_valid and out_ready are both 1.
  // While out_valid=1 and out_ready=0, every registered output holds.

  logic [0:0]       state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             valid_q, valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;

  logic [1:0]       win_base;
  logic [1:0]       win;
  logic [WIDTH-1:0] win_data;
  logic [WIDTH-1:0] cur_data;
  logic             xfer;

  // First requester found when scanning from base+1 round to base.
  function automatic logic [1:0] pick(input logic [1:0] base, input logic [3:0] r);
    logic [1:0] idx;
    logic       found;
    pick  = base;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [WIDTH-1:0] mux4(input logic [1:0] s, input logic [WIDTH-1:0] d3,
                                            input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d1,
                                            input logic [WIDTH-1:0] d0);
    case (s)
      2'd0:    mux4 = d0;
      2'd1:    mux4 = d1;
      2'd2:    mux4 = d2;
      default: mux4 = d3;
    endcase
  endfunction

  // When a grant ends, the current owner becomes the new round-robin pointer.
  assign win_base = (state_q == S_GRANT) ? sel_q : last_q;
  assign win      = pick(win_base, req);
  assign win_data = mux4(win, i3, i2, i1, i0);
  assign cur_data = mux4(sel_q, i3, i2, i1, i0);
  assign xfer     = valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    f_d     = f_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (state_q == S_IDLE) begin
      valid_d = 1'b0;
      if (req != 4'b0000) begin
        state_d = S_GRANT;
        gnt_d   = 4'b0001 << win;
        sel_d   = win;
        f_d     = win_data;
        valid_d = 1'b1;
        cnt_d   = CW'(1);
      end
    end else if (xfer) begin
      if (req[sel_q] && (cnt_q < MAX_CNT)) begin
        f_d   = cur_data;
        cnt_d = cnt_q + CW'(1);
      end else begin
        last_d = sel_q;
        if (req != 4'b0000) begin
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          f_d     = win_data;
          valid_d = 1'b1;
          cnt_d   = CW'(1);
        end else begin
          state_d = S_IDLE;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      f_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      f_q     <= f_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel1      = sel_q[1];
  assign sel0      = sel_q[0];
  assign f         = f_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == S_GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter_8bit.sv
// Bench for mux4_rr_arbiter_8bit: directed scenarios and random traffic, checked every cycle
// against a transaction-level model of the arbiter.
module tb_mux4_rr_arbiter_8bit;

  localparam int MAXB = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] i3, i2, i1, i0;
  logic       out_ready;
  logic [3:0] gnt;
  logic       sel1, sel0;
  logic [7:0] f;
  logic       out_valid;
  logic       busy;

  int n_checks;
  int n_errors;

  // Model state
  bit       m_busy;
  bit       m_valid;
  int       m_w;
  int       m_sel;
  int       m_cnt;
  int       m_last;
  bit [7:0] m_f;

  mux4_rr_arbiter_8bit #(.WIDTH(8), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .req(req),
    .i3(i3), .i2(i2), .i1(i1), .i0(i0),
    .out_ready(out_ready), .gnt(gnt), .sel1(sel1), .sel0(sel0),
    .f(f), .out_valid(out_valid), .busy(busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [7:0] word_of(input int n);
    case (n)
      0:       return i0;
      1:       return i1;
      2:       return i2;
      default: return i3;
    endcase
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_valid = 0;
    m_w     = 0;
    m_sel   = 0;
    m_cnt   = 0;
    m_last  = 3;
    m_f     = 8'h00;
  endtask

  task automatic model_load();
    for (int k = 1; k <= 4; k++) begin
      int n;
      n = (m_last + k) % 4;
      if (req[n]) begin
        m_w     = n;
        m_sel   = n;
        m_f     = word_of(n);
        m_valid = 1;
        m_cnt   = 1;
        m_busy  = 1;
        return;
      end
    end
  endtask

  task automatic model_step();
    if (!m_busy) begin
      if (req != 0) model_load();
    end else if (m_valid && out_ready) begin
      if (req[m_w] && m_cnt < MAXB) begin
        m_cnt++;
        m_f = word_of(m_w);
      end else begin
        m_last = m_w;
        if (req != 0) model_load();
        else begin
          m_busy  = 0;
          m_valid = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("gnt", 32'(gnt), m_valid ? 32'(1 << m_w) : 32'd0);
    check("sel", 32'({sel1, sel0}), 32'(m_sel));
    check("f", 32'(f), 32'(m_f));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  // Driver: inputs are already set in the low phase; one rising edge, then compare
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle, outputs checked before the next edge
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_f"}, 32'(f), 32'd0);
    check({tag, "_sel"}, 32'({sel1, sel0}), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    model_reset();
    #1 rst = 1'b0;
  endtask

  logic [7:0] exp_q[$];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    req = 4'b0000;
    {i3, i2, i1, i0} = 32'h0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compare_all();

    // Single requester: continuous stream, then a stall with the input changing
    req = 4'b0001; i0 = 8'h07; out_ready = 1'b1;
    tick();
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_f", 32'(f), 32'h07);
    for (int k = 0; k < 9; k++) begin
      tick();
      check("single_nogap", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b0; i0 = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_f", 32'(f), 32'h07);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    check("after_stall_f", 32'(f), 32'hAA);
    async_reset("rst_mid");

    // All request: 4-word bursts rotating 0,1,2,3,0
    req = 4'b1111; i3 = 8'h02; i2 = 8'h05; i1 = 8'h06; i0 = 8'h07; out_ready = 1'b1;
    foreach (exp_q[k]) exp_q.delete(k);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h07);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h06);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h05);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h02);
    exp_q.push_back(8'h07);
    while (exp_q.size() > 0) begin
      tick();
      check("rr_seq_f", 32'(f), 32'(exp_q.pop_front()));
    end
    async_reset("rst_b");

    // Early release, then idle, then the pointer after last=2
    req = 4'b0101; i0 = 8'h11; i2 = 8'h5C; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    req = 4'b0100;
    tick();
    check("early_gnt", 32'(gnt), 32'h4);
    check("early_f", 32'(f), 32'h5C);
    req = 4'b0000;
    tick();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_gnt", 32'(gnt), 32'd0);
    req = 4'b1001;
    tick();
    check("ptr_gnt", 32'(gnt), 32'h8);
    check("ptr_sel", 32'({sel1, sel0}), 32'd3);

    // Random traffic with occasional asynchronous resets
    for (int k = 0; k < 600; k++) begin
      req       = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = 4'b0000;
      i0        = 8'($urandom);
      i1        = 8'($urandom);
      i2        = 8'($urandom);
      i3        = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) async_reset("rst_rand");
      else tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
